// File: rtl/overlap_add_mc.sv
// overlap_add_mc: multi-channel overlap-add for windowed IMDCT frames.
// Each 2N-sample frame: the first half is summed with the stored second half
// of the previous frame of the same channel and emitted; the second half is
// stored for the next frame. Output is one registered stage.
// Optional feature: define OVERLAP_ADD_MC_SAT_EN to saturate the sum instead
// of letting it wrap.
module overlap_add_mc #(
    parameter int SAMPLE_W = 32,
    parameter int HALF_LEN = 1024,
    parameter int CHANNELS = 2,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_overlap_firstSequence,
    input  logic [CH_W-1:0]     in_overlap_channel,
    input  logic                in_overlap_valid,
    output logic                in_overlap_ready,
    input  logic [SAMPLE_W-1:0] in_overlap_pcmSample,
    output logic [SAMPLE_W-1:0] out_overlap_pcmSample,
    output logic [CH_W-1:0]     out_overlap_channel,
    output logic                out_overlap_last,
    output logic                out_overlap_valid,
    input  logic                out_overlap_ready
);
    localparam int IDX_W  = $clog2(2 * HALF_LEN);
    localparam int OFF_W  = IDX_W - 1;
    localparam int DEPTH  = CHANNELS * HALF_LEN;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic {HEAD, TAIL} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q;
    logic [CH_W-1:0]     ch_q;
    logic                first_q;
    logic [CHANNELS-1:0] primed_q;

    logic [SAMPLE_W-1:0] hist [DEPTH];
    logic [SAMPLE_W-1:0] hist_rd;

    logic                accept;
    logic                at_first;
    logic                at_half_end;
    logic                at_frame_end;
    logic [CH_W-1:0]     ch_in;
    logic [CH_W-1:0]     ch_cur;
    logic                first_cur;
    logic [ADDR_W-1:0]   addr;
    logic [SAMPLE_W-1:0] addend;
    logic [SAMPLE_W-1:0] y;

    // Frame bookkeeping: channel/firstSequence come straight from the port on
    // sample 0 and from the latches afterwards; one address serves both the
    // HEAD read and the TAIL write since N is a power of two.
    always_comb begin
        at_first     = (idx_q == '0);
        at_half_end  = (idx_q == IDX_W'(HALF_LEN - 1));
        at_frame_end = (idx_q == IDX_W'(2 * HALF_LEN - 1));
        ch_in        = (32'(in_overlap_channel) < CHANNELS) ? in_overlap_channel : '0;
        ch_cur       = at_first ? ch_in : ch_q;
        first_cur    = at_first ? in_overlap_firstSequence : first_q;
        addr         = ADDR_W'(ch_cur) * ADDR_W'(HALF_LEN) + ADDR_W'(idx_q[OFF_W-1:0]);
        accept       = in_overlap_valid && in_overlap_ready;
    end

    assign hist_rd = hist[addr];

    // Overlap sum; an unprimed channel or a fresh sequence ignores history.
    always_comb begin
        addend = (primed_q[ch_cur] && !first_cur) ? hist_rd : '0;
`ifdef OVERLAP_ADD_MC_SAT_EN
        begin
            logic [SAMPLE_W:0] sum_w;
            sum_w = {in_overlap_pcmSample[SAMPLE_W-1], in_overlap_pcmSample}
                  + {addend[SAMPLE_W-1], addend};
            if (sum_w[SAMPLE_W] != sum_w[SAMPLE_W-1])
                y = sum_w[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                    : {1'b0, {(SAMPLE_W-1){1'b1}}};
            else
                y = sum_w[SAMPLE_W-1:0];
        end
`else
        y = in_overlap_pcmSample + addend;
`endif
    end

    // HEAD/TAIL state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= HEAD;
        else       state_q <= state_d;
    end

    // Next state and input handshake: HEAD stalls only on a blocked output,
    // TAIL never stalls because it produces no output.
    always_comb begin
        state_d          = state_q;
        in_overlap_ready = 1'b0;
        case (state_q)
            HEAD: begin
                in_overlap_ready = !reset && (!out_overlap_valid || out_overlap_ready);
                if (accept && at_half_end) state_d = TAIL;
            end
            TAIL: begin
                in_overlap_ready = !reset;
                if (accept && at_frame_end) state_d = HEAD;
            end
            default: state_d = HEAD;
        endcase
    end

    // Index counter, per-frame latches and primed flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q    <= '0;
            ch_q     <= '0;
            first_q  <= 1'b0;
            primed_q <= '0;
        end else if (accept) begin
            idx_q <= idx_q + IDX_W'(1);
            if (at_first) begin
                ch_q    <= ch_in;
                first_q <= in_overlap_firstSequence;
            end
            if (at_frame_end) primed_q[ch_q] <= 1'b1;
        end
    end

    // History RAM: TAIL samples are stored, never cleared by reset.
    always_ff @(posedge clk) begin
        if (accept && state_q == TAIL) hist[addr] <= in_overlap_pcmSample;
    end

    // Output stage: load on a HEAD transfer, drop valid once drained, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_overlap_valid     <= 1'b0;
            out_overlap_last      <= 1'b0;
            out_overlap_pcmSample <= '0;
            out_overlap_channel   <= '0;
        end else if (accept && state_q == HEAD) begin
            out_overlap_valid     <= 1'b1;
            out_overlap_last      <= at_half_end;
            out_overlap_pcmSample <= y;
            out_overlap_channel   <= ch_cur;
        end else if (out_overlap_ready) begin
            out_overlap_valid     <= 1'b0;
        end
    end

endmodule

// File: doc/overlap_add_mc.md
OVERLAP_ADD_MC -- requirements
Module: overlap_add_mc

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 32: signed two's-complement sample width.
REQ-002 SHALL have parameter HALF_LEN, default 1024: overlap length N; one frame is 2N input samples; N is a power of two, >= 2.
REQ-003 SHALL have parameter CHANNELS, default 2: independent overlap histories, >= 1.
REQ-004 SHALL have these ports:
- clk  input  1  — the single clock; all logic on rising edge.
- reset  input  1  — synchronous, active-high.
- in_overlap_firstSequence  input  1  — sampled with frame sample 0; discard channel history.
- in_overlap_channel  input  max(1,$clog2(CHANNELS))  — channel of frame, sampled with sample 0.
- in_overlap_valid  input  1  — input sample present.
- in_overlap_ready  output  1  — block accepts input this cycle.
- in_overlap_pcmSample  input  SAMPLE_W  — windowed IMDCT sample.
- out_overlap_pcmSample  output  SAMPLE_W  — overlap-added PCM sample.
- out_overlap_channel  output  max(1,$clog2(CHANNELS))  — channel of output sample.
- out_overlap_last  output  1  — high on output sample N-1 of a frame.
- out_overlap_valid  output  1  — output sample present.
- out_overlap_ready  input  1  — downstream accepts output.

Function
REQ-005 Transfer SHALL occur on an interface when valid and ready are both high at a rising edge.
REQ-006 SHALL keep index counter idx (0..2N-1), incremented per accepted input, wrapping 2N-1 -> 0.
REQ-007 At idx=0 transfer SHALL latch channel ch and firstSequence; values at other indices are ignored.
REQ-008 in_overlap_channel >= CHANNELS SHALL be mapped to channel 0.
REQ-009 States: HEAD (idx < N), TAIL (idx >= N); HEAD->TAIL on accepting idx=N-1; TAIL->HEAD on accepting idx=2N-1.
REQ-010 In HEAD, sample x at index i SHALL produce output y = x + hist[ch][i], or y = x if ch is unprimed or firstSequence was latched high.
REQ-011 In TAIL, sample x at index i SHALL be written to hist[ch][i-N] with no output generated.
REQ-012 Accepting idx=2N-1 SHALL set primed[ch]; other channels' history and flags SHALL be unaffected.
REQ-013 Output SHALL be one registered stage: y appears on out_overlap_* the cycle after the HEAD input transfer (latency 1).
REQ-014 In HEAD, in_overlap_ready SHALL be high iff out_overlap_valid is low or out_overlap_ready is high (full throughput, no bubble).
REQ-015 In TAIL, in_overlap_ready SHALL be high unconditionally; a pending output SHALL drain concurrently.
REQ-016 While out_overlap_valid is high and out_overlap_ready low, all out_overlap_* SHALL hold stable.
REQ-017 out_overlap_valid SHALL drop after output transfer unless a new HEAD sample is accepted in the same cycle.
REQ-018 out_overlap_last SHALL be high exactly for the output from index N-1; out_overlap_channel SHALL equal the latched ch.
REQ-019 History storage SHALL be CHANNELS*N words of SAMPLE_W, one read plus one write per cycle, inferable as RAM.
REQ-020 Read and write of the same address in the same cycle cannot occur (HEAD reads, TAIL writes); no bypass is required.

Reset
REQ-021 On reset high at a clock edge: idx=0, state HEAD, out_overlap_valid=0, out_overlap_last=0, out_overlap_pcmSample=0, out_overlap_channel=0, all primed flags=0.
REQ-022 History contents SHALL NOT be cleared by reset; the cleared primed flags make them unused.
REQ-023 in_overlap_ready SHALL be low while reset is high and high in the first cycle after reset.
REQ-024 Reset mid-frame SHALL abandon the partial frame; the next accepted sample is index 0 of a new frame.

Configuration
REQ-025 Macro OVERLAP_ADD_MC_SAT_EN, when defined, SHALL saturate y to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
REQ-026 Without OVERLAP_ADD_MC_SAT_EN, y SHALL be the SAMPLE_W-bit two's-complement wrap-around sum.

Verification (SAMPLE_W=16, HALF_LEN=4, CHANNELS=2 unless stated)
REQ-027 After reset, ch0 frame 1,2,3,4,10,20,30,40, out_ready=1 -> outputs 1,2,3,4, last on 4, each one cycle after input.
REQ-028 Then ch0 frame 5,5,5,5,0,0,0,0 -> outputs 15,25,35,45; same frame with firstSequence=1 -> outputs 5,5,5,5.
REQ-029 Interleave ch0 frame (tail 100s) and ch1 frame (tail 7s), then ch0 frame of zeros -> outputs 100,100,100,100, out_overlap_channel=0.
REQ-030 History 32767 plus input 1 -> 32767 with OVERLAP_ADD_MC_SAT_EN, -32768 without; -32768 plus -1 -> -32768 / 32767.
REQ-031 out_ready held low 3 cycles during HEAD -> in_ready low after first output, output stable, no sample lost or duplicated.
REQ-032 Reset asserted at idx=5 -> out_valid=0 next cycle; next frame treated as unprimed, output equals input.
